// File: rtl/mul_issue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mul_issue : issues multiply ops to an external multiplier, one-entry      |
// |             result cache, holds the product until the memory stage takes it|
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
module mul_issue #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_a,
    input  logic [63:0]      in_b,
    input  logic             in_word,
    input  logic [4:0]       in_rd,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_result,
    output logic [4:0]       out_rd,
    output logic             mul_start,
    output logic [63:0]      mul_a,
    output logic [63:0]      mul_b,
    output logic             mul_word,
    output logic             mul_next,
    input  logic [63:0]      mul_result,
    input  logic             mul_ok,
    output logic [CNT_W-1:0] perf_mul,
    output logic [CNT_W-1:0] perf_hit
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic             accept;
    logic             complete;
    logic             hit;

    logic [63:0]      op_a;
    logic [63:0]      op_b;
    logic             op_word;
    logic [4:0]       op_rd;
    logic [63:0]      res;

    logic             cache_valid;
    logic [63:0]      cache_a;
    logic [63:0]      cache_b;
    logic             cache_word;
    logic [63:0]      cache_res;

    logic [CNT_W-1:0] cnt_mul;
    logic [CNT_W-1:0] cnt_hit;

    assign hit = cache_valid && (cache_a == in_a) && (cache_b == in_b)
                 && (cache_word == in_word);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // mul_next is forced during reset so a multiplier caught mid-operation clears.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        mul_start  = 1'b0;
        mul_next   = reset;
        accept     = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = ~flush & ~reset;
                accept   = in_valid & ~flush & ~reset;
                if (accept) begin
                    state_next = hit ? HOLD : BUSY;
                end
            end
            BUSY: begin
                // A flush drops the start request in the same cycle it clears the multiplier.
                mul_start = ~flush;
                if (flush) begin
                    mul_next   = 1'b1;
                    state_next = IDLE;
                end else if (mul_ok) begin
                    mul_next   = 1'b1;
                    complete   = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (flush || out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a        <= '0;
            op_b        <= '0;
            op_word     <= 1'b0;
            op_rd       <= '0;
            res         <= '0;
            cache_valid <= 1'b0;
            cache_a     <= '0;
            cache_b     <= '0;
            cache_word  <= 1'b0;
            cache_res   <= '0;
            cnt_mul     <= '0;
            cnt_hit     <= '0;
        end else begin
            if (accept) begin
                op_a    <= in_a;
                op_b    <= in_b;
                op_word <= in_word;
                op_rd   <= in_rd;
                if (hit) begin
                    res     <= cache_res;
                    cnt_hit <= cnt_hit + CNT_ONE;
                end
            end
            if (complete) begin
                res         <= mul_result;
                cache_valid <= 1'b1;
                cache_a     <= op_a;
                cache_b     <= op_b;
                cache_word  <= op_word;
                cache_res   <= mul_result;
                cnt_mul     <= cnt_mul + CNT_ONE;
            end
        end
    end

    assign out_result = res;
    assign out_rd     = op_rd;
    assign mul_a      = op_a;
    assign mul_b      = op_b;
    assign mul_word   = op_word;
    assign perf_mul   = cnt_mul;
    assign perf_hit   = cnt_hit;

endmodule
`default_nettype wire

// File: tb/tb_mul_issue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mul_issue : self-checking bench for mul_issue with a variable-latency  |
// |                multiplier stub and a result scoreboard                     |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
module tb_mul_issue;

    localparam int CNT_W = 32;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_a;
    logic [63:0]      in_b;
    logic             in_word;
    logic [4:0]       in_rd;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_result;
    logic [4:0]       out_rd;
    logic             mul_start;
    logic [63:0]      mul_a;
    logic [63:0]      mul_b;
    logic             mul_word;
    logic             mul_next;
    logic [63:0]      mul_result;
    logic             mul_ok;
    logic [CNT_W-1:0] perf_mul;
    logic [CNT_W-1:0] perf_hit;

    mul_issue #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_word    (in_word),
        .in_rd      (in_rd),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_word   (mul_word),
        .mul_next   (mul_next),
        .mul_result (mul_result),
        .mul_ok     (mul_ok),
        .perf_mul   (perf_mul),
        .perf_hit   (perf_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int lat    = 3;
    int mcnt;
    int ms_cnt = 0;
    int mn_cnt = 0;
    int exp_mul = 0;
    int exp_hit = 0;

    typedef struct packed {
        logic [63:0] res;
        logic [4:0]  rd;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        w;
        logic [4:0]  rd;
        logic [63:0] res;
        logic        hit;
        int          stall;
        int          lat;
    } vec_t;
    vec_t vecs[6];

    function automatic logic [63:0] mul_model(input logic [63:0] a, input logic [63:0] b,
                                              input logic w);
        logic [31:0] pw;
        logic [63:0] p;
        if (w) begin
            pw = a[31:0] * b[31:0];
            p  = {{32{pw[31]}}, pw};
        end else begin
            p = a * b;
        end
        return p;
    endfunction

    // Multiplier stub: finishes lat cycles after start, cleared by mul_next.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mcnt       <= 0;
            mul_ok     <= 1'b0;
            mul_result <= '0;
        end else if (mul_next) begin
            mcnt   <= 0;
            mul_ok <= 1'b0;
        end else if (mul_start && !mul_ok) begin
            if (mcnt >= lat - 1) begin
                mul_ok     <= 1'b1;
                mul_result <= mul_model(mul_a, mul_b, mul_word);
            end else begin
                mcnt <= mcnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (mul_start) ms_cnt++;
            if (mul_next)  mn_cnt++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic drive_op(input logic [63:0] a, input logic [63:0] b, input logic w,
                            input logic [4:0] rd);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_word  = w;
        in_rd    = rd;
    endtask

    task automatic scramble_inputs();
        in_valid = 1'b0;
        in_a     = {$urandom, $urandom};
        in_b     = {$urandom, $urandom};
        in_word  = 1'($urandom);
        in_rd    = 5'($urandom);
    endtask

    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic w, input logic [4:0] rd, input logic [63:0] res,
                          input logic is_hit, input int stall, input int l, input bit fl_hold);
        int ms0;
        int mn0;
        int waits;
        bit seen;
        sb_t e;
        logic [63:0] first_res;
        lat   = l;
        ms0   = ms_cnt;
        mn0   = mn_cnt;
        drive_op(a, b, w, rd);
        @(negedge clk);
        chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
        sbq.push_back('{res: res, rd: rd});
        if (is_hit) exp_hit++; else exp_mul++;
        @(posedge clk); #1;
        scramble_inputs();
        waits = 0;
        seen  = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            waits++;
            if (out_valid) seen = 1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s out_valid timeout actual=0 required=1", tag);
            void'(sbq.pop_front());
            return;
        end
        if (is_hit) chk({tag, " hit latency"}, 64'(waits), 64'd1);
        chk({tag, " perf_hit"}, 64'(perf_hit), 64'(exp_hit));
        first_res = out_result;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk({tag, " stall out_valid"}, 64'(out_valid), 64'd1);
            chk({tag, " stall out_result"}, out_result, first_res);
            chk({tag, " stall out_rd"}, 64'(out_rd), 64'(rd));
        end
        e = sbq.pop_front();
        if (fl_hold) begin
            flush = 1'b1;
        end else begin
            out_ready = 1'b1;
            chk({tag, " out_result"}, out_result, e.res);
            chk({tag, " out_rd"}, 64'(out_rd), 64'(e.rd));
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        flush     = 1'b0;
        @(negedge clk);
        chk({tag, " out_valid drop"}, 64'(out_valid), 64'd0);
        chk({tag, " in_ready idle"}, 64'(in_ready), 64'd1);
        chk({tag, " perf_mul"}, 64'(perf_mul), 64'(exp_mul));
        chk({tag, " mul_start cycles"}, 64'(ms_cnt - ms0), is_hit ? 64'd0 : 64'(l + 1));
        chk({tag, " mul_next pulses"}, 64'(mn_cnt - mn0), is_hit ? 64'd0 : 64'd1);
    endtask

    initial begin
        vecs[0] = '{a: -64'sd3, b: 64'd5, w: 1'b0, rd: 5'd7, res: 64'hFFFF_FFFF_FFFF_FFF1,
                    hit: 1'b0, stall: 0, lat: 3};
        vecs[1] = '{a: -64'sd3, b: 64'd5, w: 1'b0, rd: 5'd9, res: 64'hFFFF_FFFF_FFFF_FFF1,
                    hit: 1'b1, stall: 0, lat: 3};
        vecs[2] = '{a: 64'h0000_0001_8000_0000, b: 64'd2, w: 1'b1, rd: 5'd3, res: 64'd0,
                    hit: 1'b0, stall: 0, lat: 1};
        vecs[3] = '{a: 64'h0000_0001_8000_0000, b: 64'd2, w: 1'b0, rd: 5'd4,
                    res: 64'h0000_0003_0000_0000, hit: 1'b0, stall: 5, lat: 7};
        vecs[4] = '{a: 64'h1_0000, b: 64'h8000, w: 1'b1, rd: 5'd31,
                    res: 64'hFFFF_FFFF_8000_0000, hit: 1'b0, stall: 0, lat: 2};
        vecs[5] = '{a: 64'h1_0000, b: 64'h8000, w: 1'b1, rd: 5'd0,
                    res: 64'hFFFF_FFFF_8000_0000, hit: 1'b1, stall: 2, lat: 2};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_word   = 1'b0;
        in_rd     = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset in_ready", 64'(in_ready), 64'd0);
        chk("reset mul_start", 64'(mul_start), 64'd0);
        chk("reset mul_next", 64'(mul_next), 64'd1);
        chk("reset out_result", out_result, 64'd0);
        chk("reset perf_mul", 64'(perf_mul), 64'd0);
        chk("reset perf_hit", 64'(perf_hit), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post-reset mul_next", 64'(mul_next), 64'd0);

        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].w, vecs[i].rd,
                   vecs[i].res, vecs[i].hit, vecs[i].stall, vecs[i].lat, 1'b0);
        end

        // Flush alongside in_valid in IDLE: nothing accepted.
        drive_op(64'd1, 64'd1, 1'b0, 5'd1);
        flush = 1'b1;
        @(negedge clk);
        chk("idle flush in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        chk("idle flush mul_start", 64'(mul_start), 64'd0);
        chk("idle flush out_valid", 64'(out_valid), 64'd0);

        // Flush ten cycles into BUSY.
        lat = 20;
        drive_op(64'd6, 64'd7, 1'b0, 5'd5);
        @(posedge clk); #1;
        scramble_inputs();
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        chk("busy flush mul_next", 64'(mul_next), 64'd1);
        chk("busy flush mul_start", 64'(mul_start), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("busy flush out_valid", 64'(out_valid), 64'd0);
        chk("busy flush in_ready", 64'(in_ready), 64'd1);
        chk("busy flush perf_mul", 64'(perf_mul), 64'(exp_mul));
        run_op("cache kept", 64'h1_0000, 64'h8000, 1'b1, 5'd2, 64'hFFFF_FFFF_8000_0000,
               1'b1, 0, 2, 1'b0);
        run_op("after flush", 64'd6, 64'd7, 1'b0, 5'd5, 64'd42, 1'b0, 0, 4, 1'b0);

        // Flush in HOLD drops the result but keeps the cache entry.
        run_op("hold flush", -64'sd2, -64'sd4, 1'b0, 5'd12, 64'd8, 1'b0, 1, 2, 1'b1);
        run_op("hold flush rehit", -64'sd2, -64'sd4, 1'b0, 5'd13, 64'd8, 1'b1, 0, 2, 1'b0);

        // Flush in the same cycle as mul_ok: no completion, no cache write.
        lat = 3;
        drive_op(64'd3, 64'd3, 1'b0, 5'd6);
        @(posedge clk); #1;
        scramble_inputs();
        begin
            bit got_ok;
            got_ok = 0;
            for (int i = 0; i < 50 && !got_ok; i++) begin
                @(negedge clk);
                if (mul_ok) got_ok = 1;
            end
            chk("race mul_ok seen", 64'(got_ok), 64'd1);
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("race out_valid", 64'(out_valid), 64'd0);
        chk("race perf_mul", 64'(perf_mul), 64'(exp_mul));
        run_op("race retry", 64'd3, 64'd3, 1'b0, 5'd6, 64'd9, 1'b0, 0, 3, 1'b0);

        // Reset lands mid-BUSY.
        lat = 30;
        drive_op(64'd6, 64'd7, 1'b0, 5'd8);
        @(posedge clk); #1;
        scramble_inputs();
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("midreset mul_next", 64'(mul_next), 64'd1);
        chk("midreset mul_start", 64'(mul_start), 64'd0);
        chk("midreset out_valid", 64'(out_valid), 64'd0);
        chk("midreset in_ready", 64'(in_ready), 64'd0);
        chk("midreset mul_a", mul_a, 64'd0);
        chk("midreset out_rd", 64'(out_rd), 64'd0);
        chk("midreset perf_mul", 64'(perf_mul), 64'd0);
        chk("midreset perf_hit", 64'(perf_hit), 64'd0);
        @(posedge clk); #1;
        reset   = 1'b0;
        exp_mul = 0;
        exp_hit = 0;
        sbq.delete();
        run_op("post-reset miss", 64'd3, 64'd3, 1'b0, 5'd6, 64'd9, 1'b0, 0, 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
